// File: rtl/word_splitter.sv
// word_splitter: buffers one WORD_W-bit word and replays it as WORD_W/SLICE_W slices,
// low-slice-first or high-slice-first per word. Optional out_parity port under WORD_SPLIT_PARITY_EN.
module word_splitter #(
  parameter int WORD_W = 32,
  parameter int SLICE_W = 16,
  localparam int N = WORD_W / SLICE_W,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_hi_first,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
`ifdef WORD_SPLIT_PARITY_EN
  output logic               out_parity,
`endif
  output logic               state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // Once out_valid rises it stays high, with slice/idx/last stable, until out_ready takes it;
  // in_ready may depend combinationally on out_ready, out_valid never depends on in_valid.

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                hi_q, hi_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                send;
  logic                last_c;
  logic                accept;
  logic                beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      hi_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    send      = (state_q == SEND);
    last_c    = hi_q ? (idx_q == '0) : (idx_q == IDX_LAST);
    out_valid = send;
    out_slice = send ? SLICE_W'(buf_q >> (SLICE_W * int'(idx_q))) : '0;
    out_idx   = send ? idx_q : '0;
    out_last  = send & last_c;
    // A new word can only enter when the buffer is empty or its final slice leaves this edge.
    in_ready  = rst_n & (~send | (last_c & out_ready));
    accept    = in_valid & in_ready;
    beat      = send & out_ready;

    state_d = state_q;
    buf_d   = buf_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = SEND;
      buf_d   = in_word;
      hi_d    = in_hi_first;
      idx_d   = in_hi_first ? IDX_LAST : '0;
    end else if (beat) begin
      if (last_c) begin
        state_d = IDLE;
      end else begin
        idx_d = hi_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
      end
    end
  end

`ifdef WORD_SPLIT_PARITY_EN
  assign out_parity = ^out_slice;
`endif

  assign state_dbg = state_q;

endmodule
